// File: rtl/led7_scan_ctrl.sv
// led7_scan_ctrl: time-multiplexed scan controller for common-cathode
// 7-segment digits sharing one segment bus.
//
// Handshake: load is a one-cycle strobe with no ready. Every cycle it is
// high, data_in/dp_in are accepted into the shadow. Scanning picks the
// shadow up at the next frame boundary. In IDLE the load is written straight
// into the active frame.
//
// All pin outputs are registered from the next-state values, so an/seg change
// on the same edge that takes the state/idx transition.
module led7_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lzb,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [4*N_DIGITS-1:0] shadow_data, shadow_data_nx;
  logic [N_DIGITS-1:0]   shadow_dp, shadow_dp_nx;
  logic                  pending, pending_nx;
  logic [4*N_DIGITS-1:0] active_data, active_data_nx;
  logic [N_DIGITS-1:0]   active_dp, active_dp_nx;
  logic                  boundary;
  logic                  wrap;

  logic [3:0]            digit_val;
  logic                  lz_blank;
  logic [6:0]            seg_nx;
  logic                  dp_nx;
  logic [N_DIGITS-1:0]   an_nx;

  // gfedcba pattern for one BCD code; non-BCD codes light every segment.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Scan sequencing: slot counter, digit index, frame boundary detection.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    boundary = 1'b0;
    wrap     = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = '0;
          boundary = 1'b1;
        end
        BLANK: begin
          cnt_nx = cnt + CW'(1);
          if (cnt == BLANK_LAST) state_nx = SHOW;
        end
        SHOW: begin
          if (cnt == SLOT_LAST) begin
            cnt_nx   = '0;
            state_nx = BLANK;
            if (idx == IDX_LAST) begin
              idx_nx   = '0;
              wrap     = 1'b1;
              boundary = 1'b1;
            end else begin
              idx_nx = idx + IW'(1);
            end
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Frame data: boundary transfer uses the old shadow, then a load on the
  // same edge refills the shadow (or the active frame directly when idle).
  always_comb begin
    shadow_data_nx = shadow_data;
    shadow_dp_nx   = shadow_dp;
    pending_nx     = pending;
    active_data_nx = active_data;
    active_dp_nx   = active_dp;
    if (boundary && pending) begin
      active_data_nx = shadow_data;
      active_dp_nx   = shadow_dp;
      pending_nx     = 1'b0;
    end
    if (load) begin
      shadow_data_nx = data_in;
      shadow_dp_nx   = dp_in;
      if (state == IDLE) begin
        active_data_nx = data_in;
        active_dp_nx   = dp_in;
        pending_nx     = 1'b0;
      end else begin
        pending_nx = 1'b1;
      end
    end
  end

  // Pin values for the coming cycle, derived from the next state and frame.
  always_comb begin
    digit_val = 4'(active_data_nx >> {idx_nx, 2'b00});
    lz_blank  = lzb && (idx_nx != '0) &&
                ((active_data_nx >> {idx_nx, 2'b00}) == '0);
    seg_nx    = 7'd0;
    dp_nx     = 1'b0;
    an_nx     = '1;
    if (state_nx == SHOW) begin
      seg_nx = lz_blank ? 7'd0 : decode(digit_val);
      dp_nx  = active_dp_nx[idx_nx];
      an_nx  = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_nx);
    end
  end

  // State, counters and frame registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      active_data <= '0;
      active_dp   <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      shadow_data <= shadow_data_nx;
      shadow_dp   <= shadow_dp_nx;
      pending     <= pending_nx;
      active_data <= active_data_nx;
      active_dp   <= active_dp_nx;
    end
  end

  // Registered pin drivers; reset forces the display dark immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= 7'd0;
      dp         <= 1'b0;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nx;
      dp         <= dp_nx;
      an         <= an_nx;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_led7_scan_ctrl.sv
// Bench for led7_scan_ctrl: the reference model tracks the cycle position
// since scanning started and derives slot, digit and lit/dark from
// arithmetic on that position.
module tb_led7_scan_ctrl;

  localparam int N     = 4;
  localparam int SD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = N * SD;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  // clock/reset and DUT signals
  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           load;
  logic [4*N-1:0] data_in;
  logic [N-1:0]   dp_in;
  logic           lzb;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   an;
  logic           frame_done;

  always #5 clk = ~clk;

  led7_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .lzb        (lzb),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  bit             m_scan;
  int             m_t;
  logic [4*N-1:0] m_active, m_shadow;
  logic [N-1:0]   m_dp_active, m_dp_shadow;
  bit             m_pending;
  logic [N-1:0]   exp_an;
  logic [6:0]     exp_seg;
  logic           exp_dp;
  logic           exp_fd;

  task automatic model_reset();
    m_scan      = 0;
    m_t         = 0;
    m_active    = '0;
    m_shadow    = '0;
    m_dp_active = '0;
    m_dp_shadow = '0;
    m_pending   = 0;
    exp_an      = '1;
    exp_seg     = '0;
    exp_dp      = 1'b0;
    exp_fd      = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using inputs as seen at it.
  task automatic model_step();
    bit was_idle;
    bit boundary;
    int d;
    int code;
    was_idle = !m_scan;
    boundary = 0;
    exp_fd   = 1'b0;
    if (!en) begin
      m_scan = 0;
      m_t    = 0;
    end else if (was_idle) begin
      m_scan   = 1;
      m_t      = 0;
      boundary = 1;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) begin
        boundary = 1;
        exp_fd   = 1'b1;
      end
    end
    if (boundary && m_pending) begin
      m_active    = m_shadow;
      m_dp_active = m_dp_shadow;
      m_pending   = 0;
    end
    if (load) begin
      m_shadow    = data_in;
      m_dp_shadow = dp_in;
      if (was_idle) begin
        m_active    = data_in;
        m_dp_active = dp_in;
        m_pending   = 0;
      end else begin
        m_pending = 1;
      end
    end
    exp_an  = '1;
    exp_seg = '0;
    exp_dp  = 1'b0;
    if (m_scan && (m_t % SD) >= BL) begin
      d         = (m_t / SD) % N;
      code      = int'((m_active >> (4 * d)) & 16'hF);
      exp_an    = '1;
      exp_an[d] = 1'b0;
      exp_dp    = m_dp_active[d];
      if (lzb && d > 0 && (m_active >> (4 * d)) == 0) exp_seg = 7'd0;
      else exp_seg = SEG_TAB[code];
    end
  endtask

  // driver: advance one clock, update the model, check at the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(exp_seg));
    check_eq("dp", 32'(dp), 32'(exp_dp));
    check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
  endtask

  // Run until the model's frame position equals target (bounded).
  task automatic run_until_pos(input int target);
    int n;
    n = 0;
    while ((!m_scan || (m_t % FRAME) != target) && n < 4 * FRAME) begin
      cycle();
      n++;
    end
    check_eq("reach_pos_timeout", 32'(n < 4 * FRAME), 32'd1);
  endtask

  task automatic load_pulse(input logic [4*N-1:0] d, input logic [N-1:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    cycle();
    load    = 1'b0;
  endtask

  function automatic logic [3:0] rand_nibble();
    if ($urandom_range(0, 1) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    load    = 1'b0;
    data_in = '0;
    dp_in   = '0;
    lzb     = 1'b0;
    model_reset();
    #3;
    check_eq("reset_an", 32'(an), 32'hF);
    check_eq("reset_seg", 32'(seg), 32'h0);
    check_eq("reset_dp", 32'(dp), 32'h0);
    check_eq("reset_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // 1234 loaded while idle, then scan two frames
    load_pulse(16'h1234, 4'b0000);
    en = 1'b1;
    cycle();
    cycle();
    check_eq("plan_blank_an", 32'(an), 32'hF);
    cycle();
    check_eq("plan_d0_an", 32'(an), 32'b1110);
    check_eq("plan_d0_seg", 32'(seg), 32'b1100110);
    repeat (8) cycle();
    check_eq("plan_d1_an", 32'(an), 32'b1101);
    check_eq("plan_d1_seg", 32'(seg), 32'b1001111);
    repeat (60) cycle();

    // leading-zero blanking on 0070
    en = 1'b0;
    cycle();
    lzb = 1'b1;
    load_pulse(16'h0070, 4'b0000);
    en = 1'b1;
    repeat (40) cycle();

    // invalid codes and a single decimal point
    en  = 1'b0;
    lzb = 1'b0;
    cycle();
    load_pulse(16'hAB09, 4'b0100);
    en = 1'b1;
    repeat (40) cycle();

    // mid-frame load, then a second load on the wrap edge
    run_until_pos(10);
    load_pulse(16'h5678, 4'b0001);
    run_until_pos(FRAME - 1);
    load_pulse(16'h9999, 4'b1000);
    repeat (70) cycle();

    // asynchronous reset during SHOW of digit 2
    run_until_pos(2 * SD + BL + 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_an", 32'(an), 32'hF);
    check_eq("async_rst_seg", 32'(seg), 32'h0);
    check_eq("async_rst_dp", 32'(dp), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) cycle();
    load_pulse(16'h4321, 4'b0010);
    repeat (40) cycle();

    // enable dropped mid-frame, then restarted
    run_until_pos(13);
    en = 1'b0;
    repeat (3) cycle();
    en = 1'b1;
    repeat (40) cycle();

    // randomized traffic
    repeat (1500) begin
      en      = ($urandom_range(0, 59) != 0);
      load    = ($urandom_range(0, 19) == 0);
      data_in = {rand_nibble(), rand_nibble(), rand_nibble(), rand_nibble()};
      dp_in   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) lzb = ~lzb;
      cycle();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
